// File: rtl/axi_decerr_slave_pkg.sv
// Shared types, response codes and SoC address map for the default DECERR slave.
// addr_is_mapped() lets checkers confirm that only unmapped traffic reaches the slave.
package axi_decerr_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Crossbar rules: DRAM, UART, PLIC, CLINT, ROM, Debug.
    localparam int NrRules = 6;
    localparam logic [NrRules-1:0][63:0] RULE_BASE = {
        64'h0000_0000_8000_0000,
        64'h0000_0000_1000_0000,
        64'h0000_0000_0C00_0000,
        64'h0000_0000_0200_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_0000
    };
    localparam logic [NrRules-1:0][63:0] RULE_LEN = {
        64'h0000_0000_4000_0000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0400_0000,
        64'h0000_0000_000C_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_1000
    };

    function automatic logic addr_is_mapped(input logic [63:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NrRules; i++) begin
            if (addr >= RULE_BASE[i] && addr < RULE_BASE[i] + RULE_LEN[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/axi_decerr_slave_if.sv
// AXI4 channel subset seen by the default slave; W data and strobes are not carried
// because the slave discards them.
interface axi_decerr_slave_if #(
    parameter int IdWidth   = 5,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic [IdWidth-1:0]   aw_id;
    logic [AddrWidth-1:0] aw_addr;
    logic                 aw_valid;
    logic                 aw_ready;

    logic                 w_last;
    logic                 w_valid;
    logic                 w_ready;

    logic [IdWidth-1:0]   b_id;
    logic [1:0]           b_resp;
    logic                 b_valid;
    logic                 b_ready;

    logic [IdWidth-1:0]   ar_id;
    logic [AddrWidth-1:0] ar_addr;
    logic [7:0]           ar_len;
    logic                 ar_valid;
    logic                 ar_ready;

    logic [IdWidth-1:0]   r_id;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_last;
    logic                 r_valid;
    logic                 r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_valid,
        output aw_ready,
        input  w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_valid,
        input  aw_ready,
        output w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

endinterface

// File: rtl/axi_decerr_slave.sv
// Default crossbar slave: answers every request with DECERR while following burst
// framing, and records the first faulting address plus a saturating fault count.
module axi_decerr_slave
    import axi_decerr_slave_pkg::*;
#(
    parameter int IdWidth   = 5,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi_decerr_slave_if.slave    bus,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_write_o,
    output logic                 err_valid_o,
    input  logic                 err_clr_i,
    output logic [CntWidth-1:0]  err_cnt_o
);

    localparam logic [DataWidth-1:0] RDATA_ZERO = '0;

    wr_state_t            w_state_reg;
    logic                 aw_ready_reg;
    logic                 w_ready_reg;
    logic                 b_valid_reg;
    logic [IdWidth-1:0]   b_id_reg;

    rd_state_t            r_state_reg;
    logic                 ar_ready_reg;
    logic                 r_valid_reg;
    logic                 r_last_reg;
    logic [IdWidth-1:0]   r_id_reg;
    logic [7:0]           r_len_reg;
    logic [7:0]           r_cnt_reg;

    logic [AddrWidth-1:0] err_addr_reg;
    logic                 err_write_reg;
    logic                 err_valid_reg;
    logic [CntWidth-1:0]  err_cnt_reg;

    logic                 aw_hs;
    logic                 ar_hs;
    logic [1:0]           fault_inc;
    logic [CntWidth:0]    cnt_sum;

    assign aw_hs = bus.aw_valid & aw_ready_reg;
    assign ar_hs = bus.ar_valid & ar_ready_reg;

    // Write channel: accept AW, swallow every W beat up to w_last, then one B.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_reg  <= W_IDLE;
            aw_ready_reg <= 1'b1;
            w_ready_reg  <= 1'b0;
            b_valid_reg  <= 1'b0;
            b_id_reg     <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        b_id_reg     <= bus.aw_id;
                        aw_ready_reg <= 1'b0;
                        w_ready_reg  <= 1'b1;
                        w_state_reg  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.w_valid && bus.w_last) begin
                        w_ready_reg <= 1'b0;
                        b_valid_reg <= 1'b1;
                        w_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.b_ready) begin
                        b_valid_reg  <= 1'b0;
                        aw_ready_reg <= 1'b1;
                        w_state_reg  <= W_IDLE;
                    end
                end
                default: begin
                    aw_ready_reg <= 1'b1;
                    w_ready_reg  <= 1'b0;
                    b_valid_reg  <= 1'b0;
                    w_state_reg  <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel: len+1 zero-data DECERR beats; r_last is precomputed one beat ahead
    // so the output stays registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_reg  <= R_IDLE;
            ar_ready_reg <= 1'b1;
            r_valid_reg  <= 1'b0;
            r_last_reg   <= 1'b0;
            r_id_reg     <= '0;
            r_len_reg    <= '0;
            r_cnt_reg    <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_id_reg     <= bus.ar_id;
                        r_len_reg    <= bus.ar_len;
                        r_cnt_reg    <= '0;
                        r_last_reg   <= (bus.ar_len == 8'd0);
                        ar_ready_reg <= 1'b0;
                        r_valid_reg  <= 1'b1;
                        r_state_reg  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.r_ready) begin
                        if (r_last_reg) begin
                            r_valid_reg  <= 1'b0;
                            r_last_reg   <= 1'b0;
                            ar_ready_reg <= 1'b1;
                            r_state_reg  <= R_IDLE;
                        end else begin
                            r_cnt_reg  <= r_cnt_reg + 8'd1;
                            r_last_reg <= ((r_cnt_reg + 8'd1) == r_len_reg);
                        end
                    end
                end
                default: begin
                    ar_ready_reg <= 1'b1;
                    r_valid_reg  <= 1'b0;
                    r_last_reg   <= 1'b0;
                    r_state_reg  <= R_IDLE;
                end
            endcase
        end
    end

    assign fault_inc = {1'b0, aw_hs} + {1'b0, ar_hs};
    assign cnt_sum   = {1'b0, err_cnt_reg} + {{(CntWidth-1){1'b0}}, fault_inc};

    // A new fault beats a same-cycle clear; the write wins a simultaneous AR/AW tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_addr_reg  <= '0;
            err_write_reg <= 1'b0;
            err_valid_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (cnt_sum[CntWidth]) begin
                err_cnt_reg <= '1;
            end else begin
                err_cnt_reg <= cnt_sum[CntWidth-1:0];
            end

            if (aw_hs || ar_hs) begin
                if (!err_valid_reg || err_clr_i) begin
                    err_valid_reg <= 1'b1;
                    err_write_reg <= aw_hs;
                    err_addr_reg  <= aw_hs ? bus.aw_addr : bus.ar_addr;
                end
            end else if (err_clr_i) begin
                err_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.aw_ready = aw_ready_reg;
    assign bus.w_ready  = w_ready_reg;
    assign bus.b_valid  = b_valid_reg;
    assign bus.b_id     = b_id_reg;
    assign bus.b_resp   = b_valid_reg ? RESP_DECERR : RESP_OKAY;

    assign bus.ar_ready = ar_ready_reg;
    assign bus.r_valid  = r_valid_reg;
    assign bus.r_last   = r_last_reg;
    assign bus.r_id     = r_id_reg;
    assign bus.r_data   = RDATA_ZERO;
    assign bus.r_resp   = r_valid_reg ? RESP_DECERR : RESP_OKAY;

    assign err_addr_o  = err_addr_reg;
    assign err_write_o = err_write_reg;
    assign err_valid_o = err_valid_reg;
    assign err_cnt_o   = err_cnt_reg;

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed bench: stimulus pushes expected R beats / B responses into queues and a
// negedge monitor pops and compares them; a narrow-counter instance covers saturation.
module tb_axi_decerr_slave;
    import axi_decerr_slave_pkg::*;

    typedef struct {
        logic [4:0] id;
        logic       last;
    } rexp_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int r_beats  = 0;

    rexp_t      r_exp[$];
    logic [4:0] b_exp[$];

    axi_decerr_slave_if #(.IdWidth(5), .AddrWidth(64), .DataWidth(64)) m ();
    axi_decerr_slave_if #(.IdWidth(5), .AddrWidth(64), .DataWidth(64)) s ();

    logic [63:0] err_addr;
    logic        err_write;
    logic        err_valid;
    logic        err_clr;
    logic [15:0] err_cnt;

    logic [63:0] s_err_addr;
    logic        s_err_write;
    logic        s_err_valid;
    logic        s_err_clr;
    logic [3:0]  s_err_cnt;

    axi_decerr_slave #(.IdWidth(5), .AddrWidth(64), .DataWidth(64), .CntWidth(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (m),
        .err_addr_o (err_addr),
        .err_write_o(err_write),
        .err_valid_o(err_valid),
        .err_clr_i  (err_clr),
        .err_cnt_o  (err_cnt)
    );

    axi_decerr_slave #(.IdWidth(5), .AddrWidth(64), .DataWidth(64), .CntWidth(4)) dut_sat (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (s),
        .err_addr_o (s_err_addr),
        .err_write_o(s_err_write),
        .err_valid_o(s_err_valid),
        .err_clr_i  (s_err_clr),
        .err_cnt_o  (s_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL timeout_%s: handshake not seen within budget, required completion", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every R/B handshake against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (m.r_valid && m.r_ready) begin
                r_beats++;
                if (r_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_unexpected: got beat id=%0d last=%0b, required none", m.r_id, m.r_last);
                end else begin
                    rexp_t e;
                    e = r_exp.pop_front();
                    chk("r_id", 64'(m.r_id), 64'(e.id));
                    chk("r_resp", 64'(m.r_resp), 64'(2'b11));
                    chk("r_data", m.r_data, 64'h0);
                    chk("r_last", 64'(m.r_last), 64'(e.last));
                    chk("ar_ready_busy", 64'(m.ar_ready), 64'h0);
                    if (m.r_last) $display("R burst done id=%0d beats_total=%0d", m.r_id, r_beats);
                end
            end
            if (m.b_valid && m.b_ready) begin
                if (b_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected: got id=%0d, required none", m.b_id);
                end else begin
                    logic [4:0] eid;
                    eid = b_exp.pop_front();
                    chk("b_id", 64'(m.b_id), 64'(eid));
                    chk("b_resp", 64'(m.b_resp), 64'(2'b11));
                    chk("aw_ready_busy", 64'(m.aw_ready), 64'h0);
                    $display("B response id=%0d resp=%0d", m.b_id, m.b_resp);
                end
            end
            if (m.ar_valid && m.ar_ready) chk("ar_unmapped", 64'(addr_is_mapped(m.ar_addr)), 64'h0);
            if (m.aw_valid && m.aw_ready) chk("aw_unmapped", 64'(addr_is_mapped(m.aw_addr)), 64'h0);
        end
    end

    task automatic send_ar(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n;
        m.ar_id = id;
        m.ar_addr = addr;
        m.ar_len = len;
        m.ar_valid = 1'b1;
        for (int i = 0; i <= int'(len); i++) r_exp.push_back('{id: id, last: (i == int'(len))});
        n = 0;
        while (!m.ar_ready && n < 600) begin
            tick();
            n++;
        end
        if (!m.ar_ready) timeout("ar_accept");
        tick();
        m.ar_valid = 1'b0;
        $display("AR issued id=%0d addr=0x%0h len=%0d", id, addr, len);
    endtask

    task automatic send_aw(input logic [4:0] id, input logic [63:0] addr);
        int n;
        m.aw_id = id;
        m.aw_addr = addr;
        m.aw_valid = 1'b1;
        b_exp.push_back(id);
        n = 0;
        while (!m.aw_ready && n < 600) begin
            tick();
            n++;
        end
        if (!m.aw_ready) timeout("aw_accept");
        tick();
        m.aw_valid = 1'b0;
        $display("AW issued id=%0d addr=0x%0h", id, addr);
    endtask

    task automatic w_beats(input int nbeats);
        int n;
        m.w_valid = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            m.w_last = (b == nbeats - 1);
            n = 0;
            while (!m.w_ready && n < 100) begin
                tick();
                n++;
            end
            if (!m.w_ready) timeout("w_beat");
            tick();
        end
        m.w_valid = 1'b0;
        m.w_last = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int n;
        n = 0;
        while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 2000) begin
            if (rand_ready) m.r_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m.r_ready = 1'b1;
        if (r_exp.size() != 0 || b_exp.size() != 0) begin
            timeout("drain");
            r_exp.delete();
            b_exp.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int beats_before;
        rst = 1'b1;
        err_clr = 1'b0;
        s_err_clr = 1'b0;
        m.aw_id = '0; m.aw_addr = '0; m.aw_valid = 1'b0;
        m.w_last = 1'b0; m.w_valid = 1'b0; m.b_ready = 1'b1;
        m.ar_id = '0; m.ar_addr = '0; m.ar_len = '0; m.ar_valid = 1'b0; m.r_ready = 1'b1;
        s.aw_id = '0; s.aw_addr = 64'h0000_0000_0000_3000; s.aw_valid = 1'b0;
        s.w_last = 1'b1; s.w_valid = 1'b1; s.b_ready = 1'b1;
        s.ar_id = '0; s.ar_addr = 64'h0000_0000_0000_4000; s.ar_len = '0; s.ar_valid = 1'b0;
        s.r_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_aw_ready", 64'(m.aw_ready), 64'h1);
        chk("rst_ar_ready", 64'(m.ar_ready), 64'h1);
        chk("rst_w_ready", 64'(m.w_ready), 64'h0);
        chk("rst_b_valid", 64'(m.b_valid), 64'h0);
        chk("rst_r_valid", 64'(m.r_valid), 64'h0);
        chk("rst_r_last", 64'(m.r_last), 64'h0);
        chk("rst_err_valid", 64'(err_valid), 64'h0);
        chk("rst_err_addr", err_addr, 64'h0);
        chk("rst_err_cnt", 64'(err_cnt), 64'h0);

        // 1: four-beat read
        send_ar(5'd5, 64'h0000_0000_5000_0000, 8'd3);
        chk("t1_first_beat_latency", 64'(m.r_valid), 64'h1);
        chk("t1_err_addr", err_addr, 64'h0000_0000_5000_0000);
        chk("t1_err_write", 64'(err_write), 64'h0);
        chk("t1_err_valid", 64'(err_valid), 64'h1);
        chk("t1_err_cnt", 64'(err_cnt), 64'd1);
        drain(1'b0);

        // 2: early W is stalled, then a three-beat write
        m.w_valid = 1'b1;
        m.w_last = 1'b0;
        tick();
        chk("t2_early_w_ready", 64'(m.w_ready), 64'h0);
        tick();
        chk("t2_early_w_ready_hold", 64'(m.w_ready), 64'h0);
        send_aw(5'd2, 64'h0000_0000_0000_6000);
        chk("t2_err_cnt", 64'(err_cnt), 64'd2);
        chk("t2_err_addr_held", err_addr, 64'h0000_0000_5000_0000);
        chk("t2_err_write_held", 64'(err_write), 64'h0);
        w_beats(3);
        chk("t2_b_valid", 64'(m.b_valid), 64'h1);
        drain(1'b0);

        // 3: 256-beat read with random backpressure
        beats_before = r_beats;
        send_ar(5'd9, 64'h0000_0000_6000_0000, 8'd255);
        drain(1'b1);
        chk("t3_beat_count", 64'(r_beats - beats_before), 64'd256);
        chk("t3_err_cnt", 64'(err_cnt), 64'd3);

        // 4: clear, then simultaneous AR+AW with a single-beat write at min latency
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_clr_valid", 64'(err_valid), 64'h0);
        chk("t4_clr_cnt_kept", 64'(err_cnt), 64'd3);
        m.w_valid = 1'b1;
        m.w_last = 1'b1;
        m.ar_id = 5'd1; m.ar_addr = 64'h0000_0000_0000_A000; m.ar_len = 8'd0; m.ar_valid = 1'b1;
        m.aw_id = 5'd3; m.aw_addr = 64'h0000_0000_0000_B000; m.aw_valid = 1'b1;
        r_exp.push_back('{id: 5'd1, last: 1'b1});
        b_exp.push_back(5'd3);
        tick();
        m.ar_valid = 1'b0;
        m.aw_valid = 1'b0;
        $display("AR+AW issued together ar=0xA000 aw=0xB000");
        chk("t4_err_addr", err_addr, 64'h0000_0000_0000_B000);
        chk("t4_err_write", 64'(err_write), 64'h1);
        chk("t4_err_valid", 64'(err_valid), 64'h1);
        chk("t4_err_cnt", 64'(err_cnt), 64'd5);
        chk("t4_w_ready", 64'(m.w_ready), 64'h1);
        chk("t4_b_not_yet", 64'(m.b_valid), 64'h0);
        tick();
        m.w_valid = 1'b0;
        m.w_last = 1'b0;
        chk("t4_b_min_latency", 64'(m.b_valid), 64'h1);
        drain(1'b0);

        // 5: clear coincides with a new fault -> set wins
        err_clr = 1'b1;
        send_ar(5'd6, 64'h0000_0000_0000_7000, 8'd0);
        err_clr = 1'b0;
        chk("t5_err_valid", 64'(err_valid), 64'h1);
        chk("t5_err_addr", err_addr, 64'h0000_0000_0000_7000);
        chk("t5_err_write", 64'(err_write), 64'h0);
        chk("t5_err_cnt", 64'(err_cnt), 64'd6);
        drain(1'b0);

        // 5b: saturation on the 4-bit counter instance
        for (int k = 0; k < 7; k++) begin
            s.ar_valid = 1'b1;
            s.aw_valid = 1'b1;
            tick();
            s.ar_valid = 1'b0;
            s.aw_valid = 1'b0;
            repeat (4) tick();
            chk("sat_cnt_step", 64'(s_err_cnt), 64'(2 * (k + 1)));
        end
        s.ar_valid = 1'b1;
        s.aw_valid = 1'b1;
        tick();
        s.ar_valid = 1'b0;
        s.aw_valid = 1'b0;
        repeat (4) tick();
        chk("sat_cnt_double_clip", 64'(s_err_cnt), 64'hF);
        s.ar_valid = 1'b1;
        tick();
        s.ar_valid = 1'b0;
        repeat (3) tick();
        chk("sat_cnt_hold", 64'(s_err_cnt), 64'hF);
        $display("saturation sequence done cnt=%0d", s_err_cnt);

        // 6: reset during W_RESP and during beat 2 of a 4-beat read
        m.b_ready = 1'b0;
        m.w_valid = 1'b1;
        m.w_last = 1'b1;
        send_aw(5'd4, 64'h0000_0000_0000_C000);
        tick();
        m.w_valid = 1'b0;
        m.w_last = 1'b0;
        chk("t6_b_waiting", 64'(m.b_valid), 64'h1);
        send_ar(5'd7, 64'h0000_0000_0000_D000, 8'd3);
        tick();
        chk("t6_r_mid_burst", 64'(m.r_valid), 64'h1);
        chk("t6_err_cnt_pre", 64'(err_cnt), 64'd8);
        rst = 1'b1;
        #1;
        chk("t6_r_valid_async", 64'(m.r_valid), 64'h0);
        chk("t6_b_valid_async", 64'(m.b_valid), 64'h0);
        chk("t6_r_last_async", 64'(m.r_last), 64'h0);
        r_exp.delete();
        b_exp.delete();
        $display("reset asserted mid-burst");
        tick();
        tick();
        rst = 1'b0;
        m.b_ready = 1'b1;
        tick();
        chk("t6_aw_ready_after", 64'(m.aw_ready), 64'h1);
        chk("t6_ar_ready_after", 64'(m.ar_ready), 64'h1);
        chk("t6_w_ready_after", 64'(m.w_ready), 64'h0);
        chk("t6_err_valid_after", 64'(err_valid), 64'h0);
        chk("t6_err_cnt_after", 64'(err_cnt), 64'h0);
        repeat (3) tick();
        chk("t6_no_stray_r", 64'(m.r_valid), 64'h0);
        chk("t6_no_stray_b", 64'(m.b_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
